// File: rtl/strip_pkg.sv
// Shared types and sizes for the strip occupancy table and its min-select/strike stages.
// Optional build macro: STRIP_TABLE_PIPELINE_EN (used by strip_occupancy_table).
package strip_pkg;

    localparam int unsigned NUM_STRIPS = 13;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned WIDTH_W    = 8;
    localparam int unsigned MAX_WIDTH  = 128;
    localparam int unsigned STRIKE_W   = 8;

    typedef logic [ID_W-1:0]    strip_id_t;
    typedef logic [WIDTH_W-1:0] strip_width_t;

    localparam strip_width_t          MAX_WIDTH_W = WIDTH_W'(MAX_WIDTH);
    localparam logic [STRIKE_W-1:0]   STRIKE_MAX  = '1;

    // Three candidate ids carried by one request.
    typedef struct packed {
        strip_id_t id_1;
        strip_id_t id_2;
        strip_id_t id_3;
    } strip_id_set_t;

    // Candidate payload presented to the min-select stage.
    typedef struct packed {
        strip_id_set_t ids;
        strip_width_t  width_1;
        strip_width_t  width_2;
        strip_width_t  width_3;
        strip_width_t  width_in;
    } strip_cand_t;

    // Placement result returned to the requester.
    typedef struct packed {
        logic         strike;
        strip_id_t    id;
        strip_width_t x;
    } strip_result_t;

    // True when any of the three request ids matches any id of a stored set.
    function automatic logic set_hit(strip_id_t a, strip_id_t b, strip_id_t c,
                                     strip_id_set_t s);
        return (a == s.id_1) || (a == s.id_2) || (a == s.id_3) ||
               (b == s.id_1) || (b == s.id_2) || (b == s.id_3) ||
               (c == s.id_1) || (c == s.id_2) || (c == s.id_3);
    endfunction

endpackage

// File: rtl/strip_width_regfile.sv
// Occupied-width register file: NUM_STRIPS entries, three combinational read
// ports (out-of-range ids read MAX_WIDTH) and one synchronous write port.
// Ports: clk, rst (async active-low), rd_id_1..3 -> rd_data_1..3_c,
//        wr_en / wr_id / wr_data (out-of-range writes are dropped).
module strip_width_regfile
    import strip_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ID_W-1:0]    rd_id_1,
    input  logic [ID_W-1:0]    rd_id_2,
    input  logic [ID_W-1:0]    rd_id_3,
    output logic [WIDTH_W-1:0] rd_data_1_c,
    output logic [WIDTH_W-1:0] rd_data_2_c,
    output logic [WIDTH_W-1:0] rd_data_3_c,
    input  logic               wr_en,
    input  logic [ID_W-1:0]    wr_id,
    input  logic [WIDTH_W-1:0] wr_data
);

    strip_width_t mem_q [NUM_STRIPS];
    strip_width_t mem_d [NUM_STRIPS];

    // Next-state: only an in-range id can ever match an entry.
    always_comb begin
        for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_id == ID_W'(i))) begin
                mem_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read ports: default MAX_WIDTH covers ids with no matching entry.
    always_comb begin
        rd_data_1_c = MAX_WIDTH_W;
        rd_data_2_c = MAX_WIDTH_W;
        rd_data_3_c = MAX_WIDTH_W;
        for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            if (rd_id_1 == ID_W'(i)) rd_data_1_c = mem_q[i];
            if (rd_id_2 == ID_W'(i)) rd_data_2_c = mem_q[i];
            if (rd_id_3 == ID_W'(i)) rd_data_3_c = mem_q[i];
        end
    end

endmodule

// File: rtl/strip_occupancy_table.sv
// Strip occupancy table: accepts a three-candidate placement request, presents
// the candidate widths to the min-select/strike stages, and three cycles after
// accept writes back the new width (or counts a strike) and emits one result.
// Ports: clk, rst (async active-low); req_* request handshake; cand_valid,
//        strip_id_*, occupied_width_*, width_in to the mid stages;
//        min_occupied_strip_*, strike_flag, new_occupied_strip_width from them;
//        place_* result pulse; strike_count (saturating).
// Build macro STRIP_TABLE_PIPELINE_EN: accept one request per cycle unless a
// requested id is held by an in-flight stage; otherwise one request in flight.
module strip_occupancy_table
    import strip_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_W-1:0]     req_strip_id_1,
    input  logic [ID_W-1:0]     req_strip_id_2,
    input  logic [ID_W-1:0]     req_strip_id_3,
    input  logic [WIDTH_W-1:0]  req_width_in,
    output logic                cand_valid,
    output logic [ID_W-1:0]     strip_id_1,
    output logic [ID_W-1:0]     strip_id_2,
    output logic [ID_W-1:0]     strip_id_3,
    output logic [WIDTH_W-1:0]  occupied_width_1,
    output logic [WIDTH_W-1:0]  occupied_width_2,
    output logic [WIDTH_W-1:0]  occupied_width_3,
    output logic [WIDTH_W-1:0]  width_in,
    input  logic [ID_W-1:0]     min_occupied_strip_id,
    input  logic [WIDTH_W-1:0]  min_occupied_strip_width,
    input  logic                strike_flag,
    input  logic [WIDTH_W-1:0]  new_occupied_strip_width,
    output logic                place_valid,
    output logic                place_strike,
    output logic [ID_W-1:0]     place_strip_id,
    output logic [WIDTH_W-1:0]  place_x,
    output logic [STRIKE_W-1:0] strike_count
);

    logic [2:0]          infl_q, infl_d;
    strip_cand_t         cand_q, cand_d;
    strip_result_t       place_q, place_d;
    logic                place_valid_q, place_valid_d;
    logic [STRIKE_W-1:0] strike_count_q, strike_count_d;

    strip_width_t        rd_width_1_c, rd_width_2_c, rd_width_3_c;
    logic                req_fire_c;
    logic                wr_en_c;

    assign req_fire_c = req_valid & req_ready;
    // Writeback happens on the edge that retires the oldest stage.
    assign wr_en_c    = infl_q[2] & ~strike_flag;

    strip_width_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .rd_id_1     (req_strip_id_1),
        .rd_id_2     (req_strip_id_2),
        .rd_id_3     (req_strip_id_3),
        .rd_data_1_c (rd_width_1_c),
        .rd_data_2_c (rd_width_2_c),
        .rd_data_3_c (rd_width_3_c),
        .wr_en       (wr_en_c),
        .wr_id       (min_occupied_strip_id),
        .wr_data     (new_occupied_strip_width)
    );

    // Next-state: capture on accept, retire from infl[2].
    always_comb begin
        infl_d         = {infl_q[1:0], req_fire_c};
        cand_d         = cand_q;
        place_d        = place_q;
        place_valid_d  = infl_q[2];
        strike_count_d = strike_count_q;
        if (req_fire_c) begin
            cand_d.ids.id_1 = req_strip_id_1;
            cand_d.ids.id_2 = req_strip_id_2;
            cand_d.ids.id_3 = req_strip_id_3;
            cand_d.width_1  = rd_width_1_c;
            cand_d.width_2  = rd_width_2_c;
            cand_d.width_3  = rd_width_3_c;
            cand_d.width_in = req_width_in;
        end
        if (infl_q[2]) begin
            place_d.strike = strike_flag;
            place_d.id     = min_occupied_strip_id;
            place_d.x      = min_occupied_strip_width;
            if (strike_flag && (strike_count_q != STRIKE_MAX)) begin
                strike_count_d = strike_count_q + STRIKE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            infl_q         <= '0;
            cand_q         <= '0;
            place_q        <= '0;
            place_valid_q  <= 1'b0;
            strike_count_q <= '0;
        end else begin
            infl_q         <= infl_d;
            cand_q         <= cand_d;
            place_q        <= place_d;
            place_valid_q  <= place_valid_d;
            strike_count_q <= strike_count_d;
        end
    end

`ifdef STRIP_TABLE_PIPELINE_EN
    // Ids of the two older in-flight stages; stage 0 ids live in cand_q.
    strip_id_set_t ids_s1_q, ids_s1_d;
    strip_id_set_t ids_s2_q, ids_s2_d;

    always_comb begin
        ids_s1_d = cand_q.ids;
        ids_s2_d = ids_s1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ids_s1_q <= '0;
            ids_s2_q <= '0;
        end else begin
            ids_s1_q <= ids_s1_d;
            ids_s2_q <= ids_s2_d;
        end
    end

    // Stall only on an id shared with a live stage; independent of req_valid.
    always_comb begin
        req_ready = 1'b1;
        if (infl_q[0] && set_hit(req_strip_id_1, req_strip_id_2, req_strip_id_3, cand_q.ids)) begin
            req_ready = 1'b0;
        end
        if (infl_q[1] && set_hit(req_strip_id_1, req_strip_id_2, req_strip_id_3, ids_s1_q)) begin
            req_ready = 1'b0;
        end
        if (infl_q[2] && set_hit(req_strip_id_1, req_strip_id_2, req_strip_id_3, ids_s2_q)) begin
            req_ready = 1'b0;
        end
    end
`else
    // Single request in flight: IDLE only when no stage is occupied.
    assign req_ready = ~|infl_q;
`endif

    assign cand_valid       = infl_q[0];
    assign strip_id_1       = cand_q.ids.id_1;
    assign strip_id_2       = cand_q.ids.id_2;
    assign strip_id_3       = cand_q.ids.id_3;
    assign occupied_width_1 = cand_q.width_1;
    assign occupied_width_2 = cand_q.width_2;
    assign occupied_width_3 = cand_q.width_3;
    assign width_in         = cand_q.width_in;
    assign place_valid      = place_valid_q;
    assign place_strike     = place_q.strike;
    assign place_strip_id   = place_q.id;
    assign place_x          = place_q.x;
    assign strike_count     = strike_count_q;

endmodule

// File: tb/tb_strip_occupancy_table.sv
// Scoreboard bench for strip_occupancy_table with a behavioural mid stage.
module tb_strip_occupancy_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_strip_id_1, req_strip_id_2, req_strip_id_3;
    logic [7:0] req_width_in;
    logic       cand_valid;
    logic [3:0] strip_id_1, strip_id_2, strip_id_3;
    logic [7:0] occupied_width_1, occupied_width_2, occupied_width_3;
    logic [7:0] width_in;
    logic [3:0] min_occupied_strip_id;
    logic [7:0] min_occupied_strip_width;
    logic       strike_flag;
    logic [7:0] new_occupied_strip_width;
    logic       place_valid;
    logic       place_strike;
    logic [3:0] place_strip_id;
    logic [7:0] place_x;
    logic [7:0] strike_count;

    always #5 clk = ~clk;

    strip_occupancy_table dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_strip_id_1           (req_strip_id_1),
        .req_strip_id_2           (req_strip_id_2),
        .req_strip_id_3           (req_strip_id_3),
        .req_width_in             (req_width_in),
        .cand_valid               (cand_valid),
        .strip_id_1               (strip_id_1),
        .strip_id_2               (strip_id_2),
        .strip_id_3               (strip_id_3),
        .occupied_width_1         (occupied_width_1),
        .occupied_width_2         (occupied_width_2),
        .occupied_width_3         (occupied_width_3),
        .width_in                 (width_in),
        .min_occupied_strip_id    (min_occupied_strip_id),
        .min_occupied_strip_width (min_occupied_strip_width),
        .strike_flag              (strike_flag),
        .new_occupied_strip_width (new_occupied_strip_width),
        .place_valid              (place_valid),
        .place_strike             (place_strike),
        .place_strip_id           (place_strip_id),
        .place_x                  (place_x),
        .strike_count             (strike_count)
    );

`ifdef STRIP_TABLE_PIPELINE_EN
    localparam int GAP_DISJOINT = 1;
`else
    localparam int GAP_DISJOINT = 4;
`endif

    typedef struct { int cyc; int id1, id2, id3, w1, w2, w3, win; } cexp_t;
    typedef struct { int cyc; int strike, id, x, sc; } pexp_t;
    typedef struct { bit v; int strike, id, x, nw; } mres_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    last_acc = 0;
    int    tbl [13];
    int    sc = 0;
    cexp_t cq [$];
    pexp_t pq [$];
    mres_t s1, s2, s3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lane selection shared by the model and the mid stage: smallest width, lowest lane on ties.
    function automatic int pick(int a, int b, int c);
        if (a <= b && a <= c) return 0;
        if (b <= c) return 1;
        return 2;
    endfunction

    function automatic int rd(int id);
        return (id < 13) ? tbl[id] : 128;
    endfunction

    // Reference model: a request is fully resolved against the table at accept time.
    task automatic model_accept(int i1, int i2, int i3, int w);
        int r [3];
        int ids [3];
        int l, sum, strike;
        cexp_t ce;
        pexp_t pe;
        ids[0] = i1; ids[1] = i2; ids[2] = i3;
        for (int k = 0; k < 3; k++) r[k] = rd(ids[k]);
        last_acc = cyc + 1;
        ce = '{last_acc, i1, i2, i3, r[0], r[1], r[2], w};
        cq.push_back(ce);
        l      = pick(r[0], r[1], r[2]);
        sum    = r[l] + w;
        strike = (sum > 128) ? 1 : 0;
        if (strike == 0 && ids[l] < 13) tbl[ids[l]] = sum;
        if (strike == 1 && sc < 255) sc++;
        pe = '{last_acc + 3, strike, ids[l], r[l], sc};
        pq.push_back(pe);
    endtask

    // Behavioural min-select/strike stages: two cycles from cand_valid to result.
    always @(negedge clk) begin
        if (!rst) begin
            s1.v = 1'b0; s2.v = 1'b0; s3.v = 1'b0;
        end else begin
            int w [3];
            int ids [3];
            int l, sum;
            s3 = s2;
            s2 = s1;
            s1.v = cand_valid;
            if (cand_valid) begin
                w[0] = int'(occupied_width_1); w[1] = int'(occupied_width_2); w[2] = int'(occupied_width_3);
                ids[0] = int'(strip_id_1); ids[1] = int'(strip_id_2); ids[2] = int'(strip_id_3);
                l         = pick(w[0], w[1], w[2]);
                sum       = w[l] + int'(width_in);
                s1.strike = (sum > 128) ? 1 : 0;
                s1.id     = ids[l];
                s1.x      = w[l];
                s1.nw     = sum % 256;
            end
        end
        if (s3.v) begin
            strike_flag              = 1'(s3.strike);
            min_occupied_strip_id    = 4'(s3.id);
            min_occupied_strip_width = 8'(s3.x);
            new_occupied_strip_width = 8'(s3.nw);
        end else begin
            strike_flag              = 1'($urandom);
            min_occupied_strip_id    = 4'($urandom);
            min_occupied_strip_width = 8'($urandom);
            new_occupied_strip_width = 8'($urandom);
        end
    end

    // Monitor: pop and compare whenever the DUT presents a candidate set or a result.
    always @(negedge clk) begin
        cexp_t ce;
        pexp_t pe;
        if (rst) begin
            if (cand_valid) begin
                if (cq.size() == 0) chk("cand_unexpected", 1, 0);
                else begin
                    ce = cq.pop_front();
                    chk("cand_cycle", cyc, ce.cyc);
                    chk("cand_id1", int'(strip_id_1), ce.id1);
                    chk("cand_id2", int'(strip_id_2), ce.id2);
                    chk("cand_id3", int'(strip_id_3), ce.id3);
                    chk("cand_w1", int'(occupied_width_1), ce.w1);
                    chk("cand_w2", int'(occupied_width_2), ce.w2);
                    chk("cand_w3", int'(occupied_width_3), ce.w3);
                    chk("cand_width_in", int'(width_in), ce.win);
                end
            end
            if (place_valid) begin
                if (pq.size() == 0) chk("place_unexpected", 1, 0);
                else begin
                    pe = pq.pop_front();
                    chk("place_cycle", cyc, pe.cyc);
                    chk("place_strike", int'(place_strike), pe.strike);
                    chk("place_id", int'(place_strip_id), pe.id);
                    chk("place_x", int'(place_x), pe.x);
                    chk("strike_count", int'(strike_count), pe.sc);
                end
            end
        end
    end

    task automatic issue(int i1, int i2, int i3, int w, bit v, output bit fired);
        @(negedge clk);
        req_valid      = v;
        req_strip_id_1 = 4'(i1);
        req_strip_id_2 = 4'(i2);
        req_strip_id_3 = 4'(i3);
        req_width_in   = 8'(w);
        #1;
        fired = v && req_ready;
        if (fired) model_accept(i1, i2, i3, w);
        @(posedge clk);
    endtask

    task automatic send(int i1, int i2, int i3, int w, output int acc);
        bit f = 1'b0;
        for (int t = 0; t < 40 && !f; t++) issue(i1, i2, i3, w, 1'b1, f);
        if (!f) chk("accept_timeout", 0, 1);
        acc = last_acc;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        int a, prev, seen;
        bit f;
        rst = 1'b0;
        req_valid = 1'b0;
        req_strip_id_1 = '0; req_strip_id_2 = '0; req_strip_id_3 = '0;
        req_width_in = '0;
        for (int i = 0; i < 13; i++) tbl[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_cand_valid", int'(cand_valid), 0);
        chk("rst_place_valid", int'(place_valid), 0);
        chk("rst_strike_count", int'(strike_count), 0);
        chk("rst_occ_w1", int'(occupied_width_1), 0);
        chk("rst_place_x", int'(place_x), 0);
        rst = 1'b1;

        // Directed placements and boundaries
        send(0, 1, 2, 20, a);
        send(0, 1, 2, 30, a);
        send(0, 1, 2, 5, a);
        send(5, 5, 5, 60, a);
        send(5, 5, 5, 60, a);
        send(5, 5, 5, 10, a);
        send(14, 3, 4, 7, a);
        send(14, 14, 15, 0, a);
        send(6, 6, 6, 100, a);
        send(6, 6, 6, 28, a);
        send(6, 6, 6, 1, a);

        // Throughput: repeated ids, then rotating disjoint id groups
        idle(6);
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            send(7, 8, 9, 3, a);
            if (k > 0) chk("gap_same_ids", a - prev, 4);
            prev = a;
        end
        idle(6);
        for (int k = 0; k < 8; k++) begin
            send(3 * (k % 4), 3 * (k % 4) + 1, 3 * (k % 4) + 2, 2, a);
            if (k > 0) chk("gap_disjoint", a - prev, GAP_DISJOINT);
            prev = a;
        end
        idle(6);

        // Reset in cycle 2 of a request drops it
        send(2, 3, 4, 9, a);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        cq.delete();
        pq.delete();
        for (int i = 0; i < 13; i++) tbl[i] = 0;
        sc = 0;
        repeat (2) @(negedge clk);
        chk("inrst_req_ready", int'(req_ready), 1);
        chk("inrst_place_valid", int'(place_valid), 0);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (place_valid) seen++;
        end
        chk("postrst_no_place", seen, 0);
        chk("postrst_req_ready", int'(req_ready), 1);
        send(2, 3, 4, 9, a);

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 70), ($urandom_range(0, 3) != 0), f);
        end
        idle(6);

        // Strike counter saturation
        for (int k = 0; k < 260; k++) send(14, 14, 14, 1, a);
        idle(1);

        for (int t = 0; t < 40 && (cq.size() != 0 || pq.size() != 0); t++) @(negedge clk);
        chk("drain_cand", cq.size(), 0);
        chk("drain_place", pq.size(), 0);
        chk("strike_sat", int'(strike_count), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
